// File: rtl/axis_up_arb_pkg.sv
// Shared types and helpers for the upstream AXIS packet arbiter and its
// round-robin picker.
package axis_up_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int STRB_W  = 4;
  localparam logic [1:0] TUSER_UP = 2'b00;
  // Static mode only honours selects below this value.
  localparam logic [4:0] STATIC_SEL_LIMIT = 5'd5;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef logic [1:0] req_idx_t;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_onehot(input req_idx_t idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after 'last' (wrapping)
// whose request bit is set.
module axis_rr_pick
  import axis_up_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           last,
  output logic               any,
  output req_idx_t           idx
);

  req_idx_t w_cand;
  logic     w_found;

  always_comb begin
    idx     = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = last + 2'(k);
      if (!w_found && req[w_cand]) begin
        idx     = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign any = w_found;

endmodule

// File: rtl/axis_up_arb.sv
// Packet-locked arbiter sharing the upstream AXIS channel among four sources,
// with round-robin or static selection and one registered output stage.
module axis_up_arb
  import axis_up_arb_pkg::*;
#(
  parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5,
  parameter int pDATA_WIDTH                  = 32,
  parameter int pNUM_REQ                     = 4
) (
  input  logic                                             axis_clk,
  input  logic                                             axis_rst,
  input  logic [pNUM_REQ-1:0]                              s_tvalid,
  input  logic [pNUM_REQ*pDATA_WIDTH-1:0]                  s_tdata,
  input  logic [pNUM_REQ*pUSER_PROJECT_SIDEBAND_WIDTH-1:0] s_tupsb,
  input  logic [pNUM_REQ*STRB_W-1:0]                       s_tstrb,
  input  logic [pNUM_REQ*STRB_W-1:0]                       s_tkeep,
  input  logic [pNUM_REQ-1:0]                              s_tlast,
  output logic [pNUM_REQ-1:0]                              s_tready,
  output logic                                             m_tvalid,
  output logic [pDATA_WIDTH-1:0]                           m_tdata,
  output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0]          m_tupsb,
  output logic [STRB_W-1:0]                                m_tstrb,
  output logic [STRB_W-1:0]                                m_tkeep,
  output logic                                             m_tlast,
  output logic [1:0]                                       m_tuser,
  input  logic                                             m_tready,
  input  logic                                             arb_en,
  input  logic [pNUM_REQ-1:0]                              req_mask,
  input  logic [4:0]                                       user_prj_sel,
  output logic                                             grant_valid,
  output logic [1:0]                                       cur_grant
);

  arb_state_e r_state;
  req_idx_t   r_cur_grant;
  req_idx_t   r_last_grant;
  logic       r_grant_valid;

  logic                                    r_m_tvalid;
  logic [pDATA_WIDTH-1:0]                  r_m_tdata;
  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] r_m_tupsb;
  logic [STRB_W-1:0]                       r_m_tstrb;
  logic [STRB_W-1:0]                       r_m_tkeep;
  logic                                    r_m_tlast;

  logic [pDATA_WIDTH-1:0]                  w_tdata_arr [pNUM_REQ];
  logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0] w_tupsb_arr [pNUM_REQ];
  logic [STRB_W-1:0]                       w_tstrb_arr [pNUM_REQ];
  logic [STRB_W-1:0]                       w_tkeep_arr [pNUM_REQ];

  logic [pNUM_REQ-1:0] w_rr_req;
  logic                w_rr_any;
  req_idx_t            w_rr_idx;
  logic                w_pick_vld;
  req_idx_t            w_pick_idx;
  logic                w_lock;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_accept_last;

  for (genvar g = 0; g < pNUM_REQ; g++) begin : g_slice
    assign w_tdata_arr[g] = s_tdata[slice_lo(g, pDATA_WIDTH) +: pDATA_WIDTH];
    assign w_tupsb_arr[g] = s_tupsb[slice_lo(g, pUSER_PROJECT_SIDEBAND_WIDTH) +:
                                    pUSER_PROJECT_SIDEBAND_WIDTH];
    assign w_tstrb_arr[g] = s_tstrb[slice_lo(g, STRB_W) +: STRB_W];
    assign w_tkeep_arr[g] = s_tkeep[slice_lo(g, STRB_W) +: STRB_W];
  end

  assign w_rr_req = s_tvalid & req_mask;

  axis_rr_pick u_rr_pick (
    .req  (w_rr_req),
    .last (r_last_grant),
    .any  (w_rr_any),
    .idx  (w_rr_idx)
  );

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    if (arb_en) begin
      w_pick_vld = w_rr_any;
      w_pick_idx = w_rr_idx;
    end else if (user_prj_sel < STATIC_SEL_LIMIT && s_tvalid[user_prj_sel[1:0]]) begin
      w_pick_vld = 1'b1;
      w_pick_idx = user_prj_sel[1:0];
    end
  end

  // Ready is offered to the held grant whenever the output slot can take a
  // beat; it deliberately ignores the source's own tvalid.
  assign w_lock        = (r_state == LOCK);
  assign w_in_ready    = !r_m_tvalid || m_tready;
  assign w_accept      = w_lock && s_tvalid[r_cur_grant] && w_in_ready;
  assign w_accept_last = w_accept && s_tlast[r_cur_grant];
  assign s_tready      = w_lock ? (idx_onehot(r_cur_grant) & {pNUM_REQ{w_in_ready}})
                                : '0;

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state       <= IDLE;
      r_cur_grant   <= '0;
      r_last_grant  <= 2'd3;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_cur_grant   <= w_pick_idx;
            r_grant_valid <= 1'b1;
            r_state       <= LOCK;
          end
        end
        LOCK: begin
          if (w_accept_last) begin
            r_last_grant  <= r_cur_grant;
            r_grant_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tupsb  <= '0;
      r_m_tstrb  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_tdata_arr[r_cur_grant];
      r_m_tupsb  <= w_tupsb_arr[r_cur_grant];
      r_m_tstrb  <= w_tstrb_arr[r_cur_grant];
      r_m_tkeep  <= w_tkeep_arr[r_cur_grant];
      r_m_tlast  <= s_tlast[r_cur_grant];
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid    = r_m_tvalid;
  assign m_tdata     = r_m_tdata;
  assign m_tupsb     = r_m_tupsb;
  assign m_tstrb     = r_m_tstrb;
  assign m_tkeep     = r_m_tkeep;
  assign m_tlast     = r_m_tlast;
  assign m_tuser     = TUSER_UP;
  assign grant_valid = r_grant_valid;
  assign cur_grant   = r_cur_grant;

endmodule

// File: tb/tb_axis_up_arb.sv
// Bench for axis_up_arb: queue-based sources and scoreboard plus a
// rule-level model of the grant decision.
module tb_axis_up_arb;

  localparam int DW = 32;
  localparam int SW = 5;
  localparam int NR = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] u;
    logic [3:0]    s;
    logic [3:0]    k;
    logic          l;
  } beat_t;

  logic             axis_clk = 1'b0;
  logic             axis_rst;
  logic [NR-1:0]    s_tvalid;
  logic [NR*DW-1:0] s_tdata;
  logic [NR*SW-1:0] s_tupsb;
  logic [NR*4-1:0]  s_tstrb;
  logic [NR*4-1:0]  s_tkeep;
  logic [NR-1:0]    s_tlast;
  logic [NR-1:0]    s_tready;
  logic             m_tvalid;
  logic [DW-1:0]    m_tdata;
  logic [SW-1:0]    m_tupsb;
  logic [3:0]       m_tstrb;
  logic [3:0]       m_tkeep;
  logic             m_tlast;
  logic [1:0]       m_tuser;
  logic             m_tready;
  logic             arb_en;
  logic [NR-1:0]    req_mask;
  logic [4:0]       user_prj_sel;
  logic             grant_valid;
  logic [1:0]       cur_grant;

  always #5 axis_clk = ~axis_clk;

  axis_up_arb dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .s_tvalid     (s_tvalid),
    .s_tdata      (s_tdata),
    .s_tupsb      (s_tupsb),
    .s_tstrb      (s_tstrb),
    .s_tkeep      (s_tkeep),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .m_tvalid     (m_tvalid),
    .m_tdata      (m_tdata),
    .m_tupsb      (m_tupsb),
    .m_tstrb      (m_tstrb),
    .m_tkeep      (m_tkeep),
    .m_tlast      (m_tlast),
    .m_tuser      (m_tuser),
    .m_tready     (m_tready),
    .arb_en       (arb_en),
    .req_mask     (req_mask),
    .user_prj_sel (user_prj_sel),
    .grant_valid  (grant_valid),
    .cur_grant    (cur_grant)
  );

  int checks = 0;
  int errors = 0;
  int pkt_id = 0;

  beat_t src_q [NR][$];
  beat_t exp_q [NR][$];
  int    pkts_out [NR];
  int    out_order [$];

  logic [NR-1:0] hs_in = '0;
  logic          rand_ready = 1'b0;
  logic          gaps = 1'b0;
  logic          nxt_ready = 1'b1;
  logic          nxt_arb_en = 1'b1;
  logic [NR-1:0] nxt_mask = 4'hF;
  logic [4:0]    nxt_sel = 5'd0;
  int            model_last = 3;

  logic          prev_ok = 1'b0;
  logic          prev_gv, prev_mv, prev_mr, prev_en;
  logic [1:0]    prev_cg;
  logic [NR-1:0] prev_v, prev_mask;
  logic [4:0]    prev_sel;
  beat_t         prev_ob;
  logic          in_pkt = 1'b0;
  logic [1:0]    cur_src = 2'd0;

  // Grant rule: round-robin from the last finished packet, or static select.
  function automatic logic [2:0] model_pick(input logic [3:0] v, input logic [3:0] m,
                                            input logic en, input logic [4:0] sel,
                                            input int last);
    int c;
    if (en) begin
      for (int k = 1; k <= 4; k++) begin
        c = (last + k) % 4;
        if (v[c] && m[c]) return {1'b1, c[1:0]};
      end
    end else if (sel < 5'd5 && v[sel % 5'd4]) begin
      return {1'b1, sel[1:0]};
    end
    return 3'b000;
  endfunction

  function automatic logic idle_all();
    for (int i = 0; i < NR; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return !grant_valid && !m_tvalid;
  endfunction

  task automatic load(input int src, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.d = {src[1:0], pkt_id[13:0], i[7:0], 8'($urandom)};
      b.u = 5'($urandom);
      b.s = 4'($urandom);
      b.k = 4'($urandom);
      b.l = (i == nb - 1);
      src_q[src].push_back(b);
      exp_q[src].push_back(b);
    end
    pkt_id++;
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        s_tvalid[i] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        b = '0;
        s_tvalid[i] = 1'b0;
      end
      s_tdata[i*DW +: DW] = b.d;
      s_tupsb[i*SW +: SW] = b.u;
      s_tstrb[i*4 +: 4]   = b.s;
      s_tkeep[i*4 +: 4]   = b.k;
      s_tlast[i]          = b.l;
    end
    m_tready     = rand_ready ? ($urandom_range(0, 2) != 0) : nxt_ready;
    arb_en       = nxt_arb_en;
    req_mask     = nxt_mask;
    user_prj_sel = nxt_sel;
  endtask

  task automatic monitor();
    beat_t      ob;
    logic [2:0] mp;
    logic [1:0] os;
    logic [3:0] exp_rdy;
    ob = '{d: m_tdata, u: m_tupsb, s: m_tstrb, k: m_tkeep, l: m_tlast};

    checks++;
    if (m_tuser !== 2'b00) begin
      errors++; $display("FAIL tuser_const: got %b want 00", m_tuser);
    end
    exp_rdy = (grant_valid && (!m_tvalid || m_tready)) ? (4'b0001 << cur_grant) : 4'b0000;
    checks++;
    if (s_tready !== exp_rdy) begin
      errors++; $display("FAIL s_tready: got %b want %b", s_tready, exp_rdy);
    end
    if (prev_ok && prev_mv && !prev_mr) begin
      checks++;
      if ({m_tvalid, ob} !== {1'b1, prev_ob}) begin
        errors++; $display("FAIL hold_stable: got %h want %h", {m_tvalid, ob}, {1'b1, prev_ob});
      end
    end
    if (prev_ok && !prev_gv) begin
      mp = model_pick(prev_v, prev_mask, prev_en, prev_sel, model_last);
      checks++;
      if ({grant_valid, grant_valid ? cur_grant : 2'b00} !== mp) begin
        errors++; $display("FAIL pick: got %b want %b", {grant_valid, cur_grant}, mp);
      end
    end
    if (prev_ok && prev_gv && grant_valid) begin
      checks++;
      if (cur_grant !== prev_cg) begin
        errors++; $display("FAIL grant_lock: got %0d want %0d", cur_grant, prev_cg);
      end
    end
    if (m_tvalid && m_tready) begin
      os = m_tdata[31:30];
      checks++;
      if (in_pkt && os != cur_src) begin
        errors++; $display("FAIL interleave: got src %0d want src %0d", os, cur_src);
      end else if (exp_q[os].size() == 0) begin
        errors++; $display("FAIL unexpected_beat: got %h want none from src %0d", ob, os);
      end else if (ob !== exp_q[os][0]) begin
        errors++; $display("FAIL beat: got %h want %h", ob, exp_q[os][0]);
      end
      if (exp_q[os].size() > 0) void'(exp_q[os].pop_front());
      in_pkt  = !m_tlast;
      cur_src = os;
      if (m_tlast) begin
        pkts_out[os]++;
        out_order.push_back(int'(os));
      end
    end

    prev_ok   = 1'b1;
    prev_gv   = grant_valid;
    prev_cg   = cur_grant;
    prev_mv   = m_tvalid;
    prev_mr   = m_tready;
    prev_ob   = ob;
    prev_v    = s_tvalid;
    prev_mask = req_mask;
    prev_en   = arb_en;
    prev_sel  = user_prj_sel;
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs_in[i] && src_q[i].size() > 0) begin
        if (src_q[i][0].l) model_last = i;
        void'(src_q[i].pop_front());
      end
    end
    drive();
    @(negedge axis_clk);
    hs_in = s_tvalid & s_tready;
    monitor();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (n < max && !idle_all()) begin
      tick();
      n++;
    end
    checks++;
    if (!idle_all()) begin
      errors++; $display("FAIL drain_timeout: still pending after %0d cycles, want idle", n);
    end
  endtask

  task automatic bench_reset_state();
    for (int i = 0; i < NR; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    hs_in      = '0;
    model_last = 3;
    prev_ok    = 1'b0;
    in_pkt     = 1'b0;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    drive();
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tupsb, m_tstrb, m_tkeep, m_tlast, m_tuser, s_tready,
         grant_valid, cur_grant} !== '0) begin
      errors++; $display("FAIL reset_state: got m_tvalid=%b s_tready=%b gv=%b cg=%0d want all 0",
                         m_tvalid, s_tready, grant_valid, cur_grant);
    end
    @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(negedge axis_clk);
    repeat (2) tick();
  endtask

  task automatic test_rr_all();
    logic exp_v;
    nxt_ready = 1'b1; rand_ready = 1'b0; gaps = 1'b0; nxt_arb_en = 1'b1; nxt_mask = 4'hF;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NR; r++) load(r, 2);
    tick();
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp_v = (c >= 2) && ((c - 2) % 3 < 2);
      checks++;
      if (m_tvalid !== exp_v) begin
        errors++; $display("FAIL rr_valid c%0d: got %b want %b", c, m_tvalid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (m_tdata[31:30] !== 2'(((c - 2) / 3) % 4)) begin
          errors++; $display("FAIL rr_order c%0d: got %0d want %0d", c, m_tdata[31:30],
                             ((c - 2) / 3) % 4);
        end
      end
    end
    drain(100);
  endtask

  task automatic test_single_packet();
    beat_t a0, a1, a2;
    load(1, 3);
    a0 = src_q[1][0]; a1 = src_q[1][1]; a2 = src_q[1][2];
    tick();
    checks++;
    if ({m_tvalid, grant_valid} !== 2'b00) begin
      errors++; $display("FAIL sp_cycle0: got %b want 00", {m_tvalid, grant_valid});
    end
    tick();
    checks++;
    if ({grant_valid, cur_grant, s_tready, m_tvalid} !== {1'b1, 2'd1, 4'b0010, 1'b0}) begin
      errors++; $display("FAIL sp_grant: got %b want 10100100", {grant_valid, cur_grant, s_tready, m_tvalid});
    end
    tick();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, s_tready} !== {1'b1, a0.d, 1'b0, 4'b0010}) begin
      errors++; $display("FAIL sp_beat0: got %h want %h", m_tdata, a0.d);
    end
    tick();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, s_tready} !== {1'b1, a1.d, 1'b0, 4'b0010}) begin
      errors++; $display("FAIL sp_beat1: got %h want %h", m_tdata, a1.d);
    end
    tick();
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, grant_valid} !== {1'b1, a2.d, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sp_beat2: got %h last=%b gv=%b want %h last=1 gv=0",
                         m_tdata, m_tlast, grant_valid, a2.d);
    end
    drain(20);
  endtask

  task automatic test_backpressure();
    beat_t b0, b1;
    int    base;
    base = pkts_out[0];
    load(0, 4);
    b0 = src_q[0][0]; b1 = src_q[0][1];
    repeat (3) tick();
    checks++;
    if ({m_tvalid, m_tdata} !== {1'b1, b0.d}) begin
      errors++; $display("FAIL bp_beat0: got %h want %h", m_tdata, b0.d);
    end
    nxt_ready = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      tick();
      checks++;
      if ({m_tvalid, m_tdata, s_tready} !== {1'b1, b1.d, 4'b0000}) begin
        errors++; $display("FAIL bp_hold c%0d: got %h rdy=%b want %h rdy=0000", c, m_tdata, s_tready, b1.d);
      end
    end
    nxt_ready = 1'b1;
    tick();
    checks++;
    if ({m_tvalid, m_tdata, s_tready} !== {1'b1, b1.d, 4'b0001}) begin
      errors++; $display("FAIL bp_release: got %h rdy=%b want %h rdy=0001", m_tdata, s_tready, b1.d);
    end
    drain(30);
    checks++;
    if (pkts_out[0] !== base + 1) begin
      errors++; $display("FAIL bp_count: got %0d want %0d", pkts_out[0], base + 1);
    end
  endtask

  task automatic test_static();
    int base [NR];
    int n;
    for (int r = 0; r < NR; r++) base[r] = pkts_out[r];
    nxt_arb_en = 1'b0; nxt_sel = 5'd2;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < NR; r++) load(r, 1);
    n = 0;
    while (n < 60 && (exp_q[2].size() != 0 || grant_valid || m_tvalid)) begin
      tick();
      n++;
    end
    checks++;
    if ({pkts_out[2] - base[2], pkts_out[0] - base[0], pkts_out[1] - base[1], pkts_out[3] - base[3]}
        !== {32'd3, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL static_sel2: got %0d/%0d/%0d/%0d want 3/0/0/0 for src2/0/1/3",
                         pkts_out[2] - base[2], pkts_out[0] - base[0],
                         pkts_out[1] - base[1], pkts_out[3] - base[3]);
    end
    nxt_sel = 5'd7;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({m_tvalid, grant_valid} !== 2'b00) begin
        errors++; $display("FAIL static_sel7: got %b want 00", {m_tvalid, grant_valid});
      end
    end
    nxt_arb_en = 1'b1; nxt_sel = 5'd0;
    drain(200);
  endtask

  task automatic test_mask_change();
    int base1, base2, start, n;
    logic ok;
    base1 = pkts_out[1]; base2 = pkts_out[2]; start = out_order.size();
    nxt_mask = 4'hF;
    load(3, 4);
    repeat (3) tick();
    nxt_mask = 4'h1;
    load(0, 2); load(0, 2); load(1, 2); load(2, 2);
    n = 0;
    while (n < 60 && exp_q[0].size() != 0) begin
      tick();
      n++;
    end
    ok = (out_order.size() == start + 3) && (out_order[start] == 3);
    for (int i = start + 1; i < out_order.size(); i++) if (out_order[i] != 0) ok = 1'b0;
    checks++;
    if (!ok || pkts_out[1] != base1 || pkts_out[2] != base2) begin
      errors++; $display("FAIL mask_change: got %0d pkts first src %0d want 3 pkts order 3,0,0",
                         out_order.size() - start, (out_order.size() > start) ? out_order[start] : -1);
    end
    nxt_mask = 4'hF;
    drain(200);
  endtask

  task automatic test_random();
    rand_ready = 1'b1; gaps = 1'b1;
    for (int n = 0; n < 40; n++) load(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
    for (int c = 0; c < 600; c++) begin
      if (c % 25 == 0) begin
        nxt_arb_en = ($urandom_range(0, 3) != 0);
        nxt_mask   = 4'($urandom);
        nxt_sel    = 5'($urandom_range(0, 7));
      end
      tick();
    end
    gaps = 1'b0; rand_ready = 1'b0; nxt_ready = 1'b1;
    nxt_arb_en = 1'b1; nxt_mask = 4'hF; nxt_sel = 5'd0;
    drain(500);
  endtask

  task automatic test_reset_midrun();
    int base;
    load(2, 6);
    repeat (4) tick();
    #2 axis_rst = 1'b1;
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tupsb, m_tstrb, m_tkeep, m_tlast, m_tuser, s_tready,
         grant_valid, cur_grant} !== '0) begin
      errors++; $display("FAIL async_reset: got m_tvalid=%b s_tready=%b gv=%b cg=%0d want all 0",
                         m_tvalid, s_tready, grant_valid, cur_grant);
    end
    bench_reset_state();
    drive();
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    @(negedge axis_clk);
    base = pkts_out[1];
    load(1, 2);
    drain(30);
    checks++;
    if (pkts_out[1] !== base + 1) begin
      errors++; $display("FAIL post_reset: got %0d want %0d", pkts_out[1], base + 1);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) pkts_out[i] = 0;
    test_reset();
    test_rr_all();
    test_single_packet();
    test_backpressure();
    test_static();
    test_mask_change();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
